fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the asynchronous FIFO's write side among NREQ requesters in the write clock domain. Each requester presents data with a valid/ready handshake. The arbiter grants one requester at a time for a bounded burst and drives `winc`/`wdata` into `fifo_top`, gating all transfers on `wfull`. It sits directly in front of `fifo_top`, entirely in the `wclk` domain.

## Interface
- `WSIZE`, 16, data word width (matches `fifo_top` WSIZE)
- `NREQ`, 4, number of requesters (≥2)
- `BURST`, 4, maximum words accepted per grant tenure (≥1)

- `wclk`  in  1  write-domain clock; all state on rising edge
- `wrst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-requester word available
- `req_data`  in  NREQ*WSIZE  requester i word at bits [i*WSIZE +: WSIZE]
- `req_ready`  out  NREQ  per-requester word accepted this cycle
- `wfull`  in  1  FIFO full flag from `fifo_top`
- `winc`  out  1  FIFO write enable to `fifo_top`
- `wdata`  out  WSIZE  FIFO write data to `fifo_top`
- `grant_id`  out  $clog2(NREQ)  index of current owner (valid while `busy`)
- `busy`  out  1  a grant tenure is active

## Operation
- The FSM has two states: IDLE and GRANT. Registered state: `owner`, `ptr` (round-robin start), and `cnt`, which is $clog2(BURST+1) bits.
- IDLE:
  - If any `req_valid` is set, `owner` takes the first index at or after `ptr` (modulo NREQ) with `req_valid` set.
  - `cnt` is set to 0 and the FSM moves to GRANT.
  - If no `req_valid` is set, the FSM stays in IDLE.
- GRANT:
  - `req_ready[owner]` = `req_valid[owner]` & !`wfull`. All other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[owner]` & `req_ready[owner]`.
  - `winc` = transfer. `wdata` = `req_data[owner]` when `winc` = 1, otherwise 0.
  - Each transfer increments `cnt`.
- The tenure ends and the FSM returns to IDLE on either condition:
  - a transfer with `cnt` == BURST-1, or
  - `req_valid[owner]` = 0 in any GRANT cycle.
- At tenure end, `ptr` is set to (`owner`+1) mod NREQ.
- `wfull` during GRANT: no transfer occurs. `cnt` and `owner` hold and the tenure continues; a stall alone never ends a tenure.
- A requester may drop `req_valid` at any time. Its tenure ends; words not yet accepted are its own responsibility.
- `busy` = (state == GRANT). `grant_id` = `owner`.
- In IDLE, `winc` = 0 and `req_ready` = 0, independent of `wfull`.

## Timing
- Reset value of every output while `wrst_n` = 0 is 0: `req_ready`, `winc`, `wdata`, `grant_id`, `busy`.
- Reset takes effect immediately, without a clock edge. State returns to IDLE and `ptr`, `owner`, `cnt` return to 0.
- Reset mid-burst aborts the tenure. The word being presented in that cycle is not written.
- Latency: a requester whose `req_valid` is seen in IDLE at edge n is in GRANT after edge n. Its first word can be accepted in the cycle following edge n, if `wfull` = 0.
- Within a tenure, up to BURST back-to-back words are accepted, one per cycle.
- There is exactly one IDLE bubble cycle between tenures.
- `winc`, `wdata` and `req_ready` are combinational from the registered state, `req_valid`, `req_data` and `wfull`. `fifo_top` samples them on the same `wclk` edge as the handshake.
- `wfull` is honoured in the same cycle it is observed, so a write is never issued while `wfull` = 1.
- `cnt` wraps to 0 only through tenure end; it never exceeds BURST-1.
- If `owner` drops `req_valid` in the same cycle that a different requester raises it, the tenure ends this cycle and arbitration happens in the next IDLE cycle.

## Test plan
- **Reset:** assert `wrst_n` = 0 between clock edges. All outputs go to 0 without a `wclk` edge, and `busy` = 0. After release with no requests, `winc` stays 0.
- **Single requester, burst split:** requester 2 holds valid with words 0xA000..0xA005 and `wfull` = 0.
  - `grant_id` = 2, and 4 consecutive `winc` pulses write 0xA000..0xA003.
  - One IDLE cycle follows, then 0xA004 and 0xA005 are written.
  - Exactly 6 writes total, in order.
- **All four requesters continuously valid:** grant order is 0,1,2,3,0, with 4 words each and one bubble cycle between tenures. `req_ready` is one-hot or zero in every cycle.
- **`wfull` mid-burst:** requester 1 has 2 words accepted, then `wfull` = 1 for 3 cycles.
  - During the stall: `winc` = 0, `req_ready` = 0, `grant_id` stays 1, `busy` stays 1.
  - After `wfull` drops, the remaining 2 words are written and then the tenure ends.
- **Early release:** requester 0 drops valid after 2 accepted words. Its tenure ends that cycle, and requester 3 (the only other valid requester) is granted after the bubble.
- **Reset mid-burst:** pulse `wrst_n` low during requester 3's second word.
  - No write is issued in the reset cycle.
  - After release, with requesters 0 and 3 both valid, requester 0 is granted first (`ptr` = 0).

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between the requesters, the round-robin arbiter and fifo_top.
//   req_valid/req_data/req_ready : per-requester valid/ready handshake
//   wfull                        : FIFO full flag from fifo_top
//   winc/wdata                   : FIFO write strobe and data to fifo_top
//   grant_id/busy                : current owner and tenure-active status
// master = arbiter side, slave = requester/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned WSIZE = 16,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [WSIZE-1:0]      wdata;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of fifo_top (wclk domain).
// Grants one requester at a time for up to BURST words, gating every
// transfer on wfull.
//   wclk, wrst_n : write clock, asynchronous active-low reset
//   bus (master) : requester handshakes in, winc/wdata out to fifo_top,
//                  grant_id/busy status out
// winc, wdata and req_ready are combinational from the registered state and
// the current inputs; busy and grant_id come straight from registers.
module fifo_wr_arbiter #(
    parameter int unsigned WSIZE = 16,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4
) (
    input  logic               wclk,
    input  logic               wrst_n,
    fifo_wr_arbiter_if.master  bus
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(BURST + 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] ptr_q;
    logic [CW-1:0]  cnt_q;

    logic [IDW-1:0] pick;
    logic           any_valid;
    logic           own_valid;
    logic           xfer;
    logic [IDW-1:0] owner_nxt;

    // Round-robin pick: first valid at or above ptr, else first valid overall.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any_valid && bus.req_valid[j] && (IDW'(j) >= ptr_q)) begin
                pick      = IDW'(j);
                any_valid = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any_valid && bus.req_valid[j]) begin
                pick      = IDW'(j);
                any_valid = 1'b1;
            end
        end
    end

    assign own_valid = bus.req_valid[owner_q];
    assign xfer      = (state_q == GRANT) && own_valid && !bus.wfull;
    assign owner_nxt = (owner_q == LAST_ID) ? '0 : owner_q + IDW'(1);

    // Handshake and FIFO write path for the current owner only.
    always_comb begin
        bus.req_ready = '0;
        bus.wdata     = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IDW'(j) == owner_q) begin
                bus.req_ready[j] = xfer;
                if (xfer) begin
                    bus.wdata = bus.req_data[j*WSIZE +: WSIZE];
                end
            end
        end
    end

    assign bus.winc     = xfer;
    assign bus.busy     = (state_q == GRANT);
    assign bus.grant_id = owner_q;

    // Tenure control: a stall on wfull holds cnt/owner; only a dropped valid
    // or the last burst word ends the tenure.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        owner_q <= pick;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_valid) begin
                        state_q <= IDLE;
                        ptr_q   <= owner_nxt;
                        cnt_q   <= '0;
                    end else if (xfer) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            ptr_q   <= owner_nxt;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: stimulus pushes expected writes and
// point checks into queues; the negedge monitor does every comparison.
module tb_fifo_wr_arbiter;
    localparam int unsigned WSIZE = 16;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned BURST = 4;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b1;

    fifo_wr_arbiter_if #(.WSIZE(WSIZE), .NREQ(NREQ)) bus ();

    fifo_wr_arbiter #(.WSIZE(WSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.master)
    );

    always #5 wclk = ~wclk;

    int cyc = 0;
    always @(posedge wclk) cyc <= cyc + 1;

    // scoreboard queues
    logic [15:0] exp_data [$];
    logic [1:0]  exp_gid  [$];
    string       chk_name [$];
    logic [31:0] chk_act  [$];
    logic [31:0] chk_exp  [$];
    int          wr_cyc   [$];

    int total = 0;
    int bad   = 0;

    // requester models
    logic [15:0] src_base [NREQ];
    int          src_len  [NREQ];
    int          src_idx  [NREQ];
    logic [NREQ-1:0] hs;

    always @(negedge wclk) hs <= bus.req_valid & bus.req_ready;

    // monitor: compares every write and every posted point check
    int          m_t, m_b;
    logic [15:0] m_ed;
    logic [1:0]  m_eg;
    string       m_n;
    logic [31:0] m_a, m_e;
    always @(negedge wclk) begin
        m_t = 0;
        m_b = 0;
        m_t++;
        if (!$onehot0(bus.req_ready)) begin
            m_b++;
            $display("FAIL ready_onehot act=%b req=one-hot-or-zero", bus.req_ready);
        end
        m_t++;
        if (bus.winc && bus.wfull) begin
            m_b++;
            $display("FAIL write_while_full act=winc=1 req=winc=0");
        end
        if (bus.winc) begin
            wr_cyc.push_back(cyc);
            m_t++;
            if (exp_data.size() == 0) begin
                m_b++;
                $display("FAIL unexpected_write act=%h/gid%0d req=no write", bus.wdata, bus.grant_id);
            end else begin
                m_ed = exp_data.pop_front();
                m_eg = exp_gid.pop_front();
                if (bus.wdata !== m_ed || bus.grant_id !== m_eg) begin
                    m_b++;
                    $display("FAIL write_data act=%h/gid%0d req=%h/gid%0d", bus.wdata, bus.grant_id, m_ed, m_eg);
                end
            end
        end
        while (chk_name.size() > 0) begin
            m_n = chk_name.pop_front();
            m_a = chk_act.pop_front();
            m_e = chk_exp.pop_front();
            m_t++;
            if (m_a !== m_e) begin
                m_b++;
                $display("FAIL %s act=%0h req=%0h", m_n, m_a, m_e);
            end
        end
        total <= total + m_t;
        bad   <= bad + m_b;
    end

    task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
        chk_name.push_back(n);
        chk_act.push_back(a);
        chk_exp.push_back(e);
    endtask

    task automatic expect_wr(input logic [15:0] d, input logic [1:0] g);
        exp_data.push_back(d);
        exp_gid.push_back(g);
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (src_idx[i] < src_len[i]);
            bus.req_data[i*WSIZE +: WSIZE] = src_base[i] + 16'(src_idx[i]);
        end
    endtask

    task automatic load(input int i, input logic [15:0] base, input int len);
        src_base[i] = base;
        src_len[i]  = len;
        src_idx[i]  = 0;
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) if (hs[i]) src_idx[i]++;
        drive();
    endtask

    task automatic wait_writes(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (wr_cyc.size() < target && n < budget) begin
            step();
            n++;
        end
        if (wr_cyc.size() < target) post({tag, "_timeout"}, 32'(wr_cyc.size()), 32'(target));
    endtask

    task automatic wait_accepts(input int r, input int cnt, input int budget, input string tag);
        int n;
        n = 0;
        while (src_idx[r] < cnt && n < budget) begin
            step();
            n++;
        end
        if (src_idx[r] < cnt) post({tag, "_timeout"}, 32'(src_idx[r]), 32'(cnt));
    endtask

    task automatic post_zero_outputs(input string tag);
        post({tag, "_busy"},  32'(bus.busy),      32'd0);
        post({tag, "_gid"},   32'(bus.grant_id),  32'd0);
        post({tag, "_winc"},  32'(bus.winc),      32'd0);
        post({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        post({tag, "_wdata"}, 32'(bus.wdata),     32'd0);
    endtask

    task automatic post_gap(input int s, input int k, input int g, input string tag);
        post(tag, 32'(wr_cyc[s+k] - wr_cyc[s+k-1]), 32'(g));
    endtask

    task automatic reset_pulse();
        wrst_n = 1'b0;
        step();
        step();
        wrst_n = 1'b1;
    endtask

    int s, c0;

    initial begin
        for (int i = 0; i < NREQ; i++) load(i, 16'h0000, 0);
        bus.wfull = 1'b0;
        drive();
        #1 wrst_n = 1'b0;
        #2;
        post_zero_outputs("por");
        step();
        step();
        wrst_n = 1'b1;
        repeat (3) step();
        #1;
        post("idle_winc", 32'(bus.winc), 32'd0);
        post("idle_busy", 32'(bus.busy), 32'd0);

        // single requester, 6 words split 4 + 2
        s = wr_cyc.size();
        load(2, 16'hA000, 6);
        for (int k = 0; k < 6; k++) expect_wr(16'hA000 + 16'(k), 2'd2);
        c0 = cyc;
        drive();
        step();
        post("single_busy", 32'(bus.busy), 32'd1);
        post("single_gid", 32'(bus.grant_id), 32'd2);
        wait_writes(s + 6, 30, "single");
        if (wr_cyc.size() >= s + 6) begin
            post("single_latency", 32'(wr_cyc[s]), 32'(c0 + 1));
            for (int k = 1; k < 6; k++) post_gap(s, k, (k == 4) ? 2 : 1, "single_gap");
        end
        repeat (3) step();
        post("single_end_busy", 32'(bus.busy), 32'd0);

        // all four continuously valid: 0,1,2,3,0 with bubbles
        reset_pulse();
        s = wr_cyc.size();
        load(0, 16'hB000, 8);
        load(1, 16'hB100, 4);
        load(2, 16'hB200, 4);
        load(3, 16'hB300, 4);
        for (int k = 0; k < 4; k++) expect_wr(16'hB000 + 16'(k), 2'd0);
        for (int k = 0; k < 4; k++) expect_wr(16'hB100 + 16'(k), 2'd1);
        for (int k = 0; k < 4; k++) expect_wr(16'hB200 + 16'(k), 2'd2);
        for (int k = 0; k < 4; k++) expect_wr(16'hB300 + 16'(k), 2'd3);
        for (int k = 4; k < 8; k++) expect_wr(16'hB000 + 16'(k), 2'd0);
        drive();
        wait_writes(s + 20, 150, "rr");
        if (wr_cyc.size() >= s + 20)
            for (int k = 1; k < 20; k++) post_gap(s, k, (k % 4 == 0) ? 2 : 1, "rr_gap");
        repeat (3) step();

        // wfull stall after 2 words of requester 1
        s = wr_cyc.size();
        load(1, 16'hC100, 4);
        for (int k = 0; k < 4; k++) expect_wr(16'hC100 + 16'(k), 2'd1);
        drive();
        wait_accepts(1, 2, 20, "stall_pre");
        bus.wfull = 1'b1;
        repeat (3) begin
            #1;
            post("stall_winc",  32'(bus.winc),      32'd0);
            post("stall_ready", 32'(bus.req_ready), 32'd0);
            post("stall_gid",   32'(bus.grant_id),  32'd1);
            post("stall_busy",  32'(bus.busy),      32'd1);
            step();
        end
        bus.wfull = 1'b0;
        wait_writes(s + 4, 20, "stall");
        post("stall_cnt_held", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 32'd1);
        repeat (2) step();
        post("stall_end_busy", 32'(bus.busy), 32'd0);

        // early release of requester 0, requester 3 follows
        reset_pulse();
        s = wr_cyc.size();
        load(0, 16'hD000, 2);
        load(3, 16'hD300, 2);
        expect_wr(16'hD000, 2'd0);
        expect_wr(16'hD001, 2'd0);
        expect_wr(16'hD300, 2'd3);
        expect_wr(16'hD301, 2'd3);
        drive();
        wait_writes(s + 4, 30, "early");
        if (wr_cyc.size() >= s + 4) begin
            post_gap(s, 1, 1, "early_gap0");
            post_gap(s, 2, 3, "early_gap_release");
        end
        repeat (3) step();

        // reset during requester 3's second word
        reset_pulse();
        s = wr_cyc.size();
        load(3, 16'hE300, 4);
        expect_wr(16'hE300, 2'd3);
        drive();
        wait_accepts(3, 1, 20, "rstmid_pre");
        #2 wrst_n = 1'b0;
        #1;
        post_zero_outputs("rstmid");
        step();
        wrst_n = 1'b1;
        load(0, 16'hF000, 2);
        expect_wr(16'hF000, 2'd0);
        expect_wr(16'hF001, 2'd0);
        for (int k = 1; k < 4; k++) expect_wr(16'hE300 + 16'(k), 2'd3);
        drive();
        wait_writes(s + 6, 40, "rstmid");
        repeat (3) step();

        post("queue_empty", 32'(exp_data.size()), 32'd0);
        @(negedge wclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
